// File: rtl/shift_rotate_iter.sv
// Multi-cycle shift/rotate engine that moves the operand one bit per clock on a valid/ready stream.
// Optional carry_out port enabled by defining SHIFT_CARRY_EN.
module shift_rotate_iter #(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_opcode,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SHIFT_CARRY_EN
  output logic             carry_out,
`endif
  output logic [WIDTH-1:0] out_data
);

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One-bit step of the working register for the given opcode.
  function automatic logic [WIDTH-1:0] step_fn(input logic [2:0] op, input logic [WIDTH-1:0] r);
    logic [WIDTH-1:0] n;
    case (op)
      OP_SLL:  n = {r[WIDTH-2:0], 1'b0};
      OP_SRL:  n = {1'b0, r[WIDTH-1:1]};
      OP_SRA:  n = {r[WIDTH-1], r[WIDTH-1:1]};
      OP_ROL:  n = {r[WIDTH-2:0], r[WIDTH-1]};
      OP_ROR:  n = {r[0], r[WIDTH-1:1]};
      default: n = r;
    endcase
    return n;
  endfunction

`ifdef SHIFT_CARRY_EN
  // Bit that leaves its position (shifted out or wrapped around) during one step.
  function automatic logic carry_fn(input logic [2:0] op, input logic [WIDTH-1:0] r);
    logic c;
    case (op)
      OP_SLL:  c = r[WIDTH-1];
      OP_ROL:  c = r[WIDTH-1];
      OP_SRL:  c = r[0];
      OP_SRA:  c = r[0];
      OP_ROR:  c = r[0];
      default: c = 1'b0;
    endcase
    return c;
  endfunction
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] step_s;
`ifdef SHIFT_CARRY_EN
  logic             carry_q, carry_d;
`endif

  assign step_s = step_fn(op_q, work_q);

  // Next-state and next-output computation for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    op_d        = op_q;
    count_d     = count_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef SHIFT_CARRY_EN
    carry_d     = carry_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          work_d     = in_data;
          op_d       = in_opcode;
          count_d    = in_amt;
          in_ready_d = 1'b0;
          // Zero amount and pass-through opcodes complete without any step.
          if ((in_amt == {AMT_W{1'b0}}) || (in_opcode > OP_ROR)) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_data_d  = in_data;
`ifdef SHIFT_CARRY_EN
            carry_d     = 1'b0;
`endif
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d  = step_s;
        count_d = count_q - AMT_W'(1);
        if (count_q == AMT_W'(1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_data_d  = step_s;
`ifdef SHIFT_CARRY_EN
          carry_d     = carry_fn(op_q, work_q);
`endif
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        count_d     = {AMT_W{1'b0}};
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      work_q      <= {WIDTH{1'b0}};
      op_q        <= 3'd0;
      count_q     <= {AMT_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= {WIDTH{1'b0}};
`ifdef SHIFT_CARRY_EN
      carry_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      op_q        <= op_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef SHIFT_CARRY_EN
      carry_q     <= carry_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`ifdef SHIFT_CARRY_EN
  assign carry_out = carry_q;
`endif

endmodule
